// File: rtl/avr_adc_sequencer.sv
// ADC sample sequencer for the AVR SPI link: assembles 2-byte frames, scans channels
// round-robin, keeps a per-channel latest-sample bank and queues samples in a stream FIFO.
module avr_adc_sequencer #(
    parameter int NUM_CH      = 16,
    parameter int SAMPLE_BITS = 10,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   avr_ready,
    input  logic                   spi_ss,
    input  logic                   spi_done,
    input  logic [7:0]             spi_dout,
    input  logic                   scan_en,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic [3:0]             fixed_ch,
    output logic [3:0]             spi_channel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAMPLE_BITS-1:0] out_sample,
    output logic [3:0]             out_channel,
    input  logic [3:0]             rd_ch,
    output logic [SAMPLE_BITS-1:0] rd_sample,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [4:0] NUM_CH_W = 5'(NUM_CH);

    typedef enum logic [1:0] {IDLE, LOW_OK, DRAIN} state_e;

    state_e                 state_q;
    logic [7:0]             byte0_q;
    logic                   frame_err_q;
    logic [SAMPLE_BITS-1:0] bank_q [NUM_CH];
    logic [SAMPLE_BITS-1:0] fifo_sample_q [FIFO_DEPTH];
    logic [3:0]             fifo_ch_q [FIFO_DEPTH];
    logic [AW:0]            wr_ptr_q, rd_ptr_q;
    logic                   overflow_q;
    logic [3:0]             spi_ch_q, spi_ch_d;

    logic                   byte1_stb, frame_ok, accept;
    logic                   empty, full, pop, push, drop, cur_enabled;
    logic [3:0]             frame_ch;
    logic [SAMPLE_BITS-1:0] new_sample;

    // Next enabled channel strictly above cur, else the lowest enabled one, else hold.
    function automatic logic [3:0] next_ch(input logic [NUM_CH-1:0] mask, input logic [3:0] cur);
        logic [3:0] above, first;
        logic       has_above, has_any;
        above     = '0;
        first     = '0;
        has_above = 1'b0;
        has_any   = 1'b0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (mask[j]) begin
                first   = 4'(j);
                has_any = 1'b1;
                if (4'(j) > cur) begin
                    above     = 4'(j);
                    has_above = 1'b1;
                end
            end
        end
        return has_above ? above : (has_any ? first : cur);
    endfunction

    assign frame_ch   = spi_dout[7:4];
    assign byte1_stb  = spi_done && !spi_ss && (state_q == LOW_OK);
    // Bits of byte1[3:0] above the sample's upper field must be zero.
    assign frame_ok   = ({1'b0, frame_ch} < NUM_CH_W) &&
                        ((spi_dout[3:0] >> (SAMPLE_BITS - 8)) == 4'd0);
    assign accept     = byte1_stb && frame_ok;
    assign new_sample = {spi_dout[SAMPLE_BITS-9:0], byte0_q};

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && out_ready;
    assign push  = accept && (!full || pop);
    assign drop  = accept && full && !pop;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cur_enabled = 1'b0;
        rd_sample   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (spi_ch_q == 4'(i)) cur_enabled = ch_mask[i];
            if (rd_ch == 4'(i))    rd_sample   = bank_q[i];
        end
        spi_ch_d = spi_ch_q;
        if (!scan_en)
            spi_ch_d = fixed_ch;
        else if (accept || !cur_enabled)
            spi_ch_d = next_ch(ch_mask, spi_ch_q);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte0_q     <= '0;
            frame_err_q <= 1'b0;
        end else if (!avr_ready) begin
            state_q     <= IDLE;
            byte0_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (spi_ss) begin
                state_q <= IDLE;
                if (state_q == LOW_OK) frame_err_q <= 1'b1;
            end else if (spi_done) begin
                case (state_q)
                    IDLE: begin
                        byte0_q <= spi_dout;
                        state_q <= LOW_OK;
                    end
                    LOW_OK: begin
                        state_q     <= DRAIN;
                        frame_err_q <= !frame_ok;
                    end
                    default: state_q <= DRAIN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            spi_ch_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
        end else if (!avr_ready) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            spi_ch_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) bank_q[i] <= '0;
        end else begin
            spi_ch_q <= spi_ch_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)
                overflow_q <= 1'b1;
            else if (clr_overflow)
                overflow_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++)
                if (accept && frame_ch == 4'(i)) bank_q[i] <= new_sample;
        end
    end

    // NOTE: FIFO storage has no reset; slots are only read behind the pointers, and the
    // head output is gated to zero while empty. The bank is reset because it is read directly.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sample_q[wr_ptr_q[AW-1:0]] <= new_sample;
            fifo_ch_q[wr_ptr_q[AW-1:0]]     <= frame_ch;
        end
    end

    assign out_valid   = !empty;
    assign out_sample  = empty ? '0 : fifo_sample_q[rd_ptr_q[AW-1:0]];
    assign out_channel = empty ? '0 : fifo_ch_q[rd_ptr_q[AW-1:0]];
    assign spi_channel = spi_ch_q;
    assign frame_err   = frame_err_q;
    assign overflow    = overflow_q;

endmodule
